// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl
//   Iterative shift-add multiplier controller for the execute stage. One
//   partial product is added per clock through a single WIDTH+1-bit adder, so
//   a full 2*WIDTH-bit product takes WIDTH iterations plus one sign-fixup
//   cycle. Signed operands are handled by multiplying magnitudes and negating
//   the final product when the operand signs differ.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous, active-high reset
//     start      request a multiply; accepted only when not busy
//     signed_op  1 = two's-complement operands, 0 = unsigned (sampled with start)
//     a          multiplicand (sampled with start)
//     b          multiplier   (sampled with start)
//     abort      synchronous cancel of the operation in flight
//     busy       operation in progress; start ignored while high
//     done       one-cycle pulse; lo/hi valid from this cycle
//     lo         product bits [WIDTH-1:0]
//     hi         product bits [2*WIDTH-1:WIDTH]
// -----------------------------------------------------------------------------
module mul_seq_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] SIGN = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]         state;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic               neg_flag;
   logic [CW-1:0]      count;

   logic               can_accept;
   logic               accept;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod_final;
   logic               last_iter;

   // IDLE and DONE both accept a new request; abort always wins over start.
   always_comb begin
      can_accept = (state == IDLE) || (state == DONE);
      accept     = can_accept && start && !abort;
   end

   // Operand magnitudes. The most negative value maps onto itself, which is
   // the correct unsigned magnitude (2^(WIDTH-1)) at WIDTH bits.
   always_comb begin
      a_neg = signed_op && a[WIDTH-1];
      b_neg = signed_op && b[WIDTH-1];
      a_mag = a_neg ? ('0 - a) : a;
      b_mag = b_neg ? ('0 - b) : b;
   end

   // One shift-add iteration: the carry out of the upper-half add becomes the
   // new accumulator MSB as everything shifts right by one.
   always_comb begin
      addend     = mplier[0] ? mcand : '0;
      sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      prod_final = neg_flag ? ('0 - acc) : acc;
      last_iter  = (count == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         neg_flag <= 1'b0;
         count    <= '0;
         lo       <= '0;
         hi       <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  mcand    <= a_mag;
                  mplier   <= b_mag;
                  neg_flag <= a_neg ^ b_neg;
                  acc      <= '0;
                  count    <= '0;
                  state    <= RUN;
               end else begin
                  state    <= IDLE;
               end
            end

            RUN: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  acc    <= {sum, acc[WIDTH-1:1]};
                  mplier <= mplier >> 1;
                  count  <= count + CW'(1);
                  if (last_iter) begin
                     state <= SIGN;
                  end
               end
            end

            SIGN: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  lo    <= prod_final[WIDTH-1:0];
                  hi    <= prod_final[2*WIDTH-1:WIDTH];
                  state <= DONE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      busy = (state == RUN) || (state == SIGN);
      done = (state == DONE);
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_ctrl
//   Self-checking bench for mul_seq_ctrl (WIDTH=16). A cycle-level reference
//   model tracks how many cycles have elapsed since the last acceptance and
//   computes the product with plain integer multiplication; DUT outputs are
//   compared against it on every falling edge, alongside directed checks
//   against known constant products.
// -----------------------------------------------------------------------------
module tb_mul_seq_ctrl;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          signed_op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          abort;
   logic          busy;
   logic          done;
   logic [W-1:0]  lo;
   logic [W-1:0]  hi;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: phase = -1 when idle, else cycles since acceptance.
   int            phase  = -1;
   logic [31:0]   m_prod = '0;
   logic [31:0]   m_pend = '0;

   always #5 clk = ~clk;

   mul_seq_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .signed_op (signed_op),
      .a         (a),
      .b         (b),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .lo        (lo),
      .hi        (hi)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                           input logic s);
      longint p;
      if (s) p = longint'($signed(x)) * longint'($signed(y));
      else   p = longint'(x) * longint'(y);
      return p[31:0];
   endfunction

   task automatic model_update();
      if (rst) begin
         phase  = -1;
         m_prod = '0;
      end else if (phase == -1 || phase == W + 1) begin
         if (start && !abort) begin
            phase  = 0;
            m_pend = ref_mul(a, b, signed_op);
         end else begin
            phase = -1;
         end
      end else if (abort) begin
         phase = -1;
      end else begin
         phase++;
         if (phase == W + 1) m_prod = m_pend;
      end
   endtask

   // One clock: update the model at the edge, compare outputs mid-cycle.
   task automatic step();
      @(posedge clk);
      model_update();
      cyc++;
      @(negedge clk);
      check("busy", 32'(busy), 32'(phase >= 0 && phase <= W));
      check("done", 32'(done), 32'(phase == W + 1));
      check("prod", {hi, lo}, m_prod);
   endtask

   // Accept one operation and run it to completion with constant expectations.
   task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input logic [15:0] eh, input logic [15:0] el);
      int k;
      a = x; b = y; signed_op = s; start = 1'b1;
      step();
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); signed_op = 1'($urandom);
      check("busy_after_accept", 32'(busy), 32'd1);
      k = 0;
      while (!done && k < 40) begin
         step();
         k++;
      end
      check("latency", k, 32'd17);
      check("busy_in_done", 32'(busy), 32'd0);
      check("hi", 32'(hi), 32'(eh));
      check("lo", 32'(lo), 32'(el));
   endtask

   function automatic logic [15:0] pick_operand();
      logic [15:0] corners [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
      return 16'($urandom);
   endfunction

   initial begin
      int prev_done;
      int seen_done;

      rst = 1'b1; start = 1'b0; signed_op = 1'b0; a = '0; b = '0; abort = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_prod", {hi, lo}, 32'd0);
      step();
      step();
      rst = 1'b0;
      step();

      // Unsigned and signed products with known values.
      do_op(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'h0001);
      do_op(16'hFFFD, 16'h0005, 1'b1, 16'hFFFF, 16'hFFF1);
      do_op(16'h8000, 16'h8000, 1'b1, 16'h4000, 16'h0000);
      do_op(16'h8000, 16'h0001, 1'b1, 16'hFFFF, 16'h8000);
      do_op(16'h8000, 16'h0001, 1'b0, 16'h0000, 16'h8000);
      step();

      // start held high with fresh operands every cycle.
      prev_done = -1;
      start = 1'b1;
      for (int i = 0; i < 75; i++) begin
         a = pick_operand(); b = pick_operand(); signed_op = 1'($urandom);
         step();
         if (done) begin
            if (prev_done >= 0) check("done_period", cyc - prev_done, 32'd18);
            prev_done = cyc;
         end
      end
      start = 1'b0;
      check("saw_done_held", 32'(prev_done >= 0), 32'd1);
      for (int i = 0; i < 20; i++) step();

      // Abort in the fifth RUN cycle keeps the previous result.
      do_op(16'h1234, 16'h0002, 1'b0, 16'h0000, 16'h2468);
      a = 16'h00FF; b = 16'h00FF; signed_op = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      seen_done = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (done) seen_done = 1;
      end
      check("abort_no_done", seen_done, 32'd0);
      check("abort_keep", {hi, lo}, 32'h0000_2468);

      // abort together with start in IDLE drops the request.
      a = 16'h0003; b = 16'h0003; start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      check("abort_start_idle", 32'(busy), 32'd0);
      step();

      // Asynchronous reset in the middle of RUN.
      a = 16'h7FFF; b = 16'h7FFF; signed_op = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) step();
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_prod", {hi, lo}, 32'd0);
      step();
      rst = 1'b0;
      step();
      do_op(16'h0000, 16'hABCD, 1'($urandom), 16'h0000, 16'h0000);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         start     = ($urandom_range(0, 2) != 0);
         abort     = ($urandom_range(0, 40) == 0);
         signed_op = 1'($urandom);
         a         = pick_operand();
         b         = pick_operand();
         step();
      end
      start = 1'b0; abort = 1'b0;
      for (int i = 0; i < 20; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Iterative shift-add multiply controller for the 16-bit CPU execute stage. It sequences one partial-product add per clock, so a single WIDTH-bit adder replaces the flat adder chain.
- Supports signed and unsigned operands.
- Produces the full 2*WIDTH product as hi/lo halves, ready for the HI/LO write-back.
- Uses a start/busy/done handshake with the decode/issue logic, plus a synchronous abort for pipeline flush.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  request a multiply; accepted only when busy=0
signed_op  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
a  in  WIDTH  multiplicand; sampled with start
b  in  WIDTH  multiplier; sampled with start
abort  in  1  synchronous cancel of the operation in flight
busy  out  1  operation in progress; start ignored while high
done  out  1  one-cycle pulse; lo/hi valid from this cycle
lo  out  WIDTH  product bits [WIDTH-1:0]
hi  out  WIDTH  product bits [2*WIDTH-1:WIDTH]

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, lo=0, hi=0.
  - Counter, accumulator and sign flag cleared.
  - Takes effect immediately, including mid-operation; no done is produced for the killed operation.
- States: IDLE, RUN, SIGN, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1 and abort=0 at an edge (the acceptance edge E0):
    - Latch signed_op.
    - If signed_op=1: operand registers take |a| and |b| as WIDTH-bit unsigned values (0x8000 stays 0x8000); neg_flag = a[MSB] XOR b[MSB].
    - If signed_op=0: operands latched unchanged; neg_flag = 0.
  - Accumulator (2*WIDTH) cleared; count=0; go to RUN.
- RUN:
  - busy=1.
  - Each edge: if multiplier LSB=1, add multiplicand into accumulator upper half (WIDTH+1-bit add, carry kept); shift {carry, accumulator, multiplier} right by 1; count++.
  - After the WIDTH-th iteration (edge E_WIDTH), go to SIGN.
- SIGN:
  - busy=1.
  - At edge E_WIDTH+1: if neg_flag, two's-complement negate the 2*WIDTH result.
  - Load lo/hi; go to DONE.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - Next edge: if start=1 and abort=0, accept a new operation exactly as in IDLE (back-to-back, go to RUN); otherwise go to IDLE.
- Latency: done is high in the cycle following edge E_WIDTH+1, i.e. WIDTH+1 cycles after acceptance (17 for WIDTH=16). Back-to-back throughput is one result per WIDTH+2 cycles.
- Output holding:
  - lo/hi change only on the SIGN→DONE load (or reset).
  - They hold the last result indefinitely, including through later aborted operations.
- start while busy=1: ignored, no side effects; the operation in flight continues.
- abort:
  - In RUN or SIGN: next state is IDLE; lo/hi unchanged; no done.
  - In IDLE or DONE: abort has priority over a simultaneous start; start is dropped.
  - abort=1 in DONE does not retract the done pulse already presented that cycle.
- Width rule: the product always fits in 2*WIDTH bits. Signed results are exact, including (-2^(W-1))^2 = 2^(2W-2).
- The operand inputs a and b are don't-care except at the acceptance edge.

Test Plan:
1. Unsigned 0xFFFF × 0xFFFF → busy high from E0; done pulses exactly 17 cycles after acceptance with hi=0xFFFE, lo=0x0001; busy=0 in the done cycle.
2. Signed: 0xFFFD (-3) × 0x0005 → hi=0xFFFF, lo=0xFFF1. Signed 0x8000 × 0x8000 → hi=0x4000, lo=0x0000. Signed 0x8000 × 0x0001 → hi=0xFFFF, lo=0x8000, versus unsigned on the same inputs → hi=0x0000, lo=0x8000.
3. Handshake: start=1 held every cycle with new operands each cycle:
   - No second acceptance occurs until the DONE cycle.
   - A new operation is accepted there (busy high the next cycle).
   - Results correspond to the operands present at each acceptance edge; done occurs every 18 cycles.
4. Abort: start 0x1234 × 0x0002 to completion (lo=0x2468, hi=0x0000). Then start 0x00FF × 0x00FF and assert abort on the 5th RUN cycle:
   - busy=0 next cycle; no done ever follows.
   - lo=0x2468 and hi=0x0000 retained.
   - Also check abort+start together in IDLE → nothing accepted.
5. Async reset: assert rst mid-edge during RUN of 0x7FFF × 0x7FFF → busy, done, lo, hi go to 0 without waiting for clk. After release, 0x0000 × 0xABCD → hi=0x0000, lo=0x0000 after 17 cycles.
